// File: rtl/ghost_pkg.sv
// Shared types and constants for the ghost sprite renderer.
package ghost_pkg;

  typedef enum logic [1:0] {
    NORMAL     = 2'd0,
    FRIGHT     = 2'd1,
    FRIGHT_END = 2'd2,
    HIDDEN     = 2'd3
  } ghost_mode_t;

  typedef enum logic [1:0] {
    FETCH_IDLE = 2'd0,
    FETCH_ADDR = 2'd1,
    FETCH_LOAD = 2'd2
  } fetch_state_t;

  localparam int SPRITE_SIZE = 32;
  localparam int H_TOTAL     = 800;
  localparam int V_TOTAL     = 525;

  // True when an 11-bit signed offset lands inside the 32-pixel sprite (0..31).
  function automatic logic in_sprite(input logic [10:0] offset);
    return (offset[10:5] == 6'd0);
  endfunction

endpackage

// File: rtl/ghost_blink_timer.sv
// Frightened-ending blink timer: counts frames spent in FRIGHT_END and
// toggles flash every BLINK_FRAMES frames. The first frame of a FRIGHT_END
// run always shows the frightened colour.
module ghost_blink_timer #(
  parameter int BLINK_FRAMES = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic frame_start_i,
  input  logic cur_end_i,   // currently latched mode is FRIGHT_END
  input  logic next_end_i,  // mode being latched at this frame_start is FRIGHT_END
  output logic flash_o
);

  localparam int CW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [CW-1:0] WRAP = CW'(BLINK_FRAMES - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          flash_q, flash_d;

  // Next-state: advance only across consecutive FRIGHT_END frames, else clear.
  always_comb begin
    cnt_d   = cnt_q;
    flash_d = flash_q;
    if (frame_start_i) begin
      if (cur_end_i && next_end_i) begin
        if (cnt_q == WRAP) begin
          cnt_d   = '0;
          flash_d = ~flash_q;
        end else begin
          cnt_d   = cnt_q + CW'(1);
          flash_d = flash_q;
        end
      end else begin
        cnt_d   = '0;
        flash_d = 1'b0;
      end
    end else begin
      cnt_d   = cnt_q;
      flash_d = flash_q;
    end
  end

  // Counter and flash registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      flash_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      flash_q <= flash_d;
    end
  end

  assign flash_o = flash_q;

endmodule

// File: rtl/ghost_sprite_renderer.sv
// Per-scanline ghost sprite renderer: fetches one bitmap row per line from an
// external combinational ROM and serialises it into ghost_on / ghost_rgb.
module ghost_sprite_renderer
  import ghost_pkg::*;
#(
  parameter logic [23:0] BODY_RGB     = 24'hFF0000,
  parameter logic [23:0] FRIGHT_RGB   = 24'h2121DE,
  parameter logic [23:0] FLASH_RGB    = 24'hFFFFFF,
  parameter int          BLINK_FRAMES = 8
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        frame_start,
  input  logic        line_start,
  input  logic        pixel_en,
  input  logic [9:0]  DrawX,
  input  logic [9:0]  DrawY,
  input  logic [9:0]  GhostX,
  input  logic [9:0]  GhostY,
  input  logic [1:0]  ghost_mode,
  output logic [4:0]  rom_addr,
  input  logic [31:0] rom_data,
  output logic        ghost_on,
  output logic [23:0] ghost_rgb
);

  logic [9:0]   gx_q, gy_q;
  ghost_mode_t  mode_q;
  fetch_state_t state_q;
  logic [4:0]   rom_addr_q;
  logic         hit_q;
  logic [31:0]  row_reg_q;
  logic         ghost_on_q;
  logic [23:0]  ghost_rgb_q;

  ghost_mode_t  mode_in_s, mode_eff_s;
  logic [9:0]   gy_eff_s, drawy_next_s;
  logic [10:0]  row_s, col_s;
  logic [4:0]   bit_idx_s;
  logic         pix_on_s;
  logic [23:0]  colour_s;
  logic         flash_s;

  assign mode_in_s = ghost_mode_t'(ghost_mode);

  // Frame latch: position and mode only change on frame_start.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      gx_q   <= 10'd0;
      gy_q   <= 10'd0;
      mode_q <= HIDDEN;
    end else if (frame_start) begin
      gx_q   <= GhostX;
      gy_q   <= GhostY;
      mode_q <= mode_in_s;
    end else begin
      gx_q   <= gx_q;
      gy_q   <= gy_q;
      mode_q <= mode_q;
    end
  end

  // Row offset for the upcoming line; a coincident frame_start wins so the
  // fetch already sees the new position and mode.
  always_comb begin
    gy_eff_s     = frame_start ? GhostY : gy_q;
    mode_eff_s   = frame_start ? mode_in_s : mode_q;
    drawy_next_s = (DrawY == 10'(V_TOTAL - 1)) ? 10'd0 : (DrawY + 10'd1);
    row_s        = {1'b0, drawy_next_s} - {1'b0, gy_eff_s};
  end

  // Fetch FSM: address goes out the cycle after line_start, row lands one later.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q    <= FETCH_IDLE;
      rom_addr_q <= 5'd0;
      hit_q      <= 1'b0;
      row_reg_q  <= 32'd0;
    end else begin
      case (state_q)
        FETCH_IDLE: begin
          if (line_start) begin
            rom_addr_q <= row_s[4:0];
            hit_q      <= in_sprite(row_s) && (mode_eff_s != HIDDEN);
            state_q    <= FETCH_ADDR;
          end else begin
            state_q    <= FETCH_IDLE;
          end
        end
        FETCH_ADDR: begin
          row_reg_q <= hit_q ? rom_data : 32'd0;
          state_q   <= FETCH_LOAD;
        end
        FETCH_LOAD: begin
          state_q <= FETCH_IDLE;
        end
        default: begin
          state_q <= FETCH_IDLE;
        end
      endcase
    end
  end

  // Column offset and bitmap lookup; columns outside 0..31 (including a
  // sprite hanging past the right edge) are transparent, never wrapped.
  always_comb begin
    col_s     = {1'b0, DrawX} - {1'b0, gx_q};
    bit_idx_s = 5'd31 - col_s[4:0];
    if (in_sprite(col_s) && (mode_q != HIDDEN)) begin
      pix_on_s = row_reg_q[bit_idx_s];
    end else begin
      pix_on_s = 1'b0;
    end
  end

  // Body colour by latched mode.
  always_comb begin
    colour_s = 24'd0;
    case (mode_q)
      NORMAL:     colour_s = BODY_RGB;
      FRIGHT:     colour_s = FRIGHT_RGB;
      FRIGHT_END: colour_s = flash_s ? FLASH_RGB : FRIGHT_RGB;
      default:    colour_s = 24'd0;
    endcase
  end

  // Pixel output registers, updated once per displayed pixel and held between.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      ghost_on_q  <= 1'b0;
      ghost_rgb_q <= 24'd0;
    end else if (pixel_en) begin
      ghost_on_q  <= pix_on_s;
      ghost_rgb_q <= pix_on_s ? colour_s : 24'd0;
    end else begin
      ghost_on_q  <= ghost_on_q;
      ghost_rgb_q <= ghost_rgb_q;
    end
  end

  ghost_blink_timer #(
    .BLINK_FRAMES (BLINK_FRAMES)
  ) u_blink (
    .clk           (Clk),
    .rst_n         (Reset_n),
    .frame_start_i (frame_start),
    .cur_end_i     (mode_q == FRIGHT_END),
    .next_end_i    (mode_in_s == FRIGHT_END),
    .flash_o       (flash_s)
  );

  assign rom_addr  = rom_addr_q;
  assign ghost_on  = ghost_on_q;
  assign ghost_rgb = ghost_rgb_q;

endmodule

// File: tb/tb_ghost_sprite_renderer.sv
// Directed bench for ghost_sprite_renderer: a vector table of single-line
// scenarios plus hand-written blink, same-cycle and reset sequences.
module tb_ghost_sprite_renderer;

  localparam logic [23:0] BODY_C   = 24'hFF0000;
  localparam logic [23:0] FRIGHT_C = 24'h2121DE;
  localparam logic [23:0] FLASH_C  = 24'hFFFFFF;
  localparam logic [31:0] ROW5_PAT = 32'h001F_F800; // columns 11..20 opaque

  logic        Clk = 1'b0;
  logic        Reset_n = 1'b0;
  logic        frame_start = 1'b0;
  logic        line_start = 1'b0;
  logic        pixel_en = 1'b0;
  logic [9:0]  DrawX = 10'd0;
  logic [9:0]  DrawY = 10'd0;
  logic [9:0]  GhostX = 10'd0;
  logic [9:0]  GhostY = 10'd0;
  logic [1:0]  ghost_mode = 2'd0;
  logic [4:0]  rom_addr;
  logic [31:0] rom_data;
  logic        ghost_on;
  logic [23:0] ghost_rgb;
  logic        rom_ones = 1'b1;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [9:0]  gx;
    logic [9:0]  gy;
    logic [1:0]  mode;
    logic        ones;
    logic [9:0]  drawy;
    logic [9:0]  x;
    logic [4:0]  exp_addr;
    logic        exp_on;
    logic [23:0] exp_rgb;
  } vec_t;

  vec_t vecs[$];

  ghost_sprite_renderer #(
    .BODY_RGB     (BODY_C),
    .FRIGHT_RGB   (FRIGHT_C),
    .FLASH_RGB    (FLASH_C),
    .BLINK_FRAMES (2)
  ) dut (
    .Clk         (Clk),
    .Reset_n     (Reset_n),
    .frame_start (frame_start),
    .line_start  (line_start),
    .pixel_en    (pixel_en),
    .DrawX       (DrawX),
    .DrawY       (DrawY),
    .GhostX      (GhostX),
    .GhostY      (GhostY),
    .ghost_mode  (ghost_mode),
    .rom_addr    (rom_addr),
    .rom_data    (rom_data),
    .ghost_on    (ghost_on),
    .ghost_rgb   (ghost_rgb)
  );

  always #5 Clk = ~Clk;

  // Behavioural ROM: all-ones, or a single patterned row at address 5.
  assign rom_data = rom_ones ? 32'hFFFF_FFFF : ((rom_addr == 5'd5) ? ROW5_PAT : 32'd0);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic do_frame(input logic [9:0] gx, input logic [9:0] gy, input logic [1:0] mode);
    GhostX = gx; GhostY = gy; ghost_mode = mode;
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
  endtask

  task automatic do_line(input string name, input logic [9:0] drawy, input logic [4:0] exp_addr);
    DrawY = drawy;
    line_start = 1'b1;
    step();
    line_start = 1'b0;
    check({name, "_addr"}, 32'(rom_addr), 32'(exp_addr));
    step();
    step();
  endtask

  task automatic do_pix(input logic [9:0] x);
    DrawX = x;
    pixel_en = 1'b1;
    step();
    pixel_en = 1'b0;
  endtask

  task automatic check_pix(input string name, input logic exp_on, input logic [23:0] exp_rgb);
    check({name, "_on"}, 32'(ghost_on), 32'(exp_on));
    check({name, "_rgb"}, 32'(ghost_rgb), 32'(exp_rgb));
  endtask

  function automatic vec_t mk(input logic [9:0] gx, input logic [9:0] gy, input logic [1:0] mode,
                              input logic ones, input logic [9:0] drawy, input logic [9:0] x,
                              input logic [4:0] exp_addr, input logic exp_on, input logic [23:0] exp_rgb);
    vec_t v;
    v.gx = gx; v.gy = gy; v.mode = mode; v.ones = ones; v.drawy = drawy; v.x = x;
    v.exp_addr = exp_addr; v.exp_on = exp_on; v.exp_rgb = exp_rgb;
    return v;
  endfunction

  logic [23:0] blink_exp [6];

  initial begin
    // Row 5 of sprite at (100,200): DrawY=204 -> next line 205 -> row 5.
    vecs.push_back(mk(10'd100, 10'd200, 2'd0, 1'b0, 10'd204, 10'd110, 5'd5,  1'b0, 24'd0));
    vecs.push_back(mk(10'd100, 10'd200, 2'd0, 1'b0, 10'd204, 10'd111, 5'd5,  1'b1, BODY_C));
    vecs.push_back(mk(10'd100, 10'd200, 2'd0, 1'b0, 10'd204, 10'd115, 5'd5,  1'b1, BODY_C));
    vecs.push_back(mk(10'd100, 10'd200, 2'd0, 1'b0, 10'd204, 10'd120, 5'd5,  1'b1, BODY_C));
    vecs.push_back(mk(10'd100, 10'd200, 2'd0, 1'b0, 10'd204, 10'd121, 5'd5,  1'b0, 24'd0));
    vecs.push_back(mk(10'd100, 10'd200, 2'd1, 1'b0, 10'd204, 10'd115, 5'd5,  1'b1, FRIGHT_C));
    vecs.push_back(mk(10'd100, 10'd200, 2'd3, 1'b1, 10'd204, 10'd115, 5'd5,  1'b0, 24'd0));
    // Rows 32 and -1 relative to gy=200 miss the sprite.
    vecs.push_back(mk(10'd100, 10'd200, 2'd0, 1'b1, 10'd231, 10'd100, 5'd0,  1'b0, 24'd0));
    vecs.push_back(mk(10'd100, 10'd200, 2'd0, 1'b1, 10'd198, 10'd100, 5'd31, 1'b0, 24'd0));
    // DrawY=524 wraps to line 0.
    vecs.push_back(mk(10'd100, 10'd0,   2'd0, 1'b1, 10'd524, 10'd100, 5'd0,  1'b1, BODY_C));
    // gy past 448: visible rows still draw, remainder simply never appears.
    vecs.push_back(mk(10'd100, 10'd500, 2'd0, 1'b1, 10'd519, 10'd100, 5'd20, 1'b1, BODY_C));
    // gx=620: columns 620..639 drawn, column 0 does not wrap.
    vecs.push_back(mk(10'd620, 10'd200, 2'd0, 1'b1, 10'd214, 10'd619, 5'd15, 1'b0, 24'd0));
    vecs.push_back(mk(10'd620, 10'd200, 2'd0, 1'b1, 10'd214, 10'd620, 5'd15, 1'b1, BODY_C));
    vecs.push_back(mk(10'd620, 10'd200, 2'd0, 1'b1, 10'd214, 10'd639, 5'd15, 1'b1, BODY_C));
    vecs.push_back(mk(10'd620, 10'd200, 2'd0, 1'b1, 10'd214, 10'd0,   5'd15, 1'b0, 24'd0));
    // First frame of frightened-ending uses the frightened colour.
    vecs.push_back(mk(10'd100, 10'd200, 2'd2, 1'b1, 10'd204, 10'd100, 5'd5,  1'b1, FRIGHT_C));

    blink_exp[0] = FRIGHT_C; blink_exp[1] = FRIGHT_C;
    blink_exp[2] = FLASH_C;  blink_exp[3] = FLASH_C;
    blink_exp[4] = FRIGHT_C; blink_exp[5] = FRIGHT_C;

    // Reset held with the ROM driving all-ones and line activity present.
    rom_ones = 1'b1;
    DrawY = 10'd204;
    repeat (2) step();
    line_start = 1'b1; pixel_en = 1'b1;
    step();
    line_start = 1'b0; pixel_en = 1'b0;
    check("rst_addr", 32'(rom_addr), 32'd0);
    check_pix("rst", 1'b0, 24'd0);
    Reset_n = 1'b1;
    step();

    // Table-driven single-line scenarios.
    for (int i = 0; i < vecs.size(); i++) begin
      rom_ones = vecs[i].ones;
      do_frame(vecs[i].gx, vecs[i].gy, vecs[i].mode);
      do_line($sformatf("vec%0d", i), vecs[i].drawy, vecs[i].exp_addr);
      do_pix(vecs[i].x);
      check_pix($sformatf("vec%0d", i), vecs[i].exp_on, vecs[i].exp_rgb);
    end

    // Blink sequence with BLINK_FRAMES=2, then mode 0 clears flash.
    rom_ones = 1'b1;
    do_frame(10'd100, 10'd200, 2'd0);
    for (int f = 0; f < 6; f++) begin
      do_frame(10'd100, 10'd200, 2'd2);
      do_line($sformatf("blink%0d", f + 1), 10'd204, 5'd5);
      do_pix(10'd100);
      check_pix($sformatf("blink%0d", f + 1), 1'b1, blink_exp[f]);
    end
    do_frame(10'd100, 10'd200, 2'd2);
    do_line("blink7", 10'd204, 5'd5);
    do_pix(10'd100);
    check_pix("blink7", 1'b1, FLASH_C);
    do_frame(10'd100, 10'd200, 2'd0);
    do_line("blink_norm", 10'd204, 5'd5);
    do_pix(10'd100);
    check_pix("blink_norm", 1'b1, BODY_C);
    do_frame(10'd100, 10'd200, 2'd2);
    do_line("blink_reent", 10'd204, 5'd5);
    do_pix(10'd100);
    check_pix("blink_reent", 1'b1, FRIGHT_C);

    // frame_start and line_start together: fetch must use the new gy=300.
    rom_ones = 1'b0;
    do_frame(10'd100, 10'd200, 2'd0);
    GhostY = 10'd300; frame_start = 1'b1;
    DrawY = 10'd304;  line_start = 1'b1;
    step();
    frame_start = 1'b0; line_start = 1'b0;
    check("same_cyc_addr", 32'(rom_addr), 32'd5);
    step();
    step();
    do_pix(10'd111);
    check_pix("same_cyc", 1'b1, BODY_C);
    // Output holds until the next pixel_en.
    DrawX = 10'd500;
    step();
    check("hold_on", 32'(ghost_on), 32'd1);

    // line_start while the fetch is busy is ignored.
    do_frame(10'd100, 10'd200, 2'd0);
    DrawY = 10'd204; line_start = 1'b1;
    step();
    DrawY = 10'd210;
    step();
    step();
    line_start = 1'b0;
    check("busy_addr", 32'(rom_addr), 32'd5);
    do_pix(10'd111);
    check_pix("busy", 1'b1, BODY_C);

    // Asynchronous reset mid-line clears state before the next edge.
    #2;
    Reset_n = 1'b0;
    #1;
    check("arst_addr", 32'(rom_addr), 32'd0);
    check_pix("arst", 1'b0, 24'd0);
    step();
    step();
    Reset_n = 1'b1;
    rom_ones = 1'b1;
    // No frame_start yet: latched mode is hidden, line renders transparent.
    do_line("post_rst", 10'd9, 5'd10);
    do_pix(10'd5);
    check_pix("post_rst", 1'b0, 24'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
